// File: rtl/regfile_write_sched_if.sv
// rtl/regfile_write_sched_if.sv - writeback, reservation, query and register-file port bundle
interface regfile_write_sched_if #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32
);
   logic                          alu_valid;
   logic                          alu_ready;
   logic [ADDRESS_WIDTH-1:0]      alu_rd;
   logic [DATA_WIDTH-1:0]         alu_data;
   logic                          lsu_valid;
   logic                          lsu_ready;
   logic [ADDRESS_WIDTH-1:0]      lsu_rd;
   logic [DATA_WIDTH-1:0]         lsu_data;
   logic                          rsv_valid;
   logic [ADDRESS_WIDTH-1:0]      rsv_rd;
   logic                          rsv_ready;
   logic [ADDRESS_WIDTH-1:0]      q_rs1;
   logic [ADDRESS_WIDTH-1:0]      q_rs2;
   logic                          busy_rs1;
   logic                          busy_rs2;
   logic                          WE3;
   logic [ADDRESS_WIDTH-1:0]      AD3;
   logic [DATA_WIDTH-1:0]         WD3;
   logic [(2**ADDRESS_WIDTH)-1:0] busy_vec;
   logic                          err_unrsv;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output lsu_valid, lsu_rd, lsu_data,
      output rsv_valid, rsv_rd, q_rs1, q_rs2,
      input  alu_ready, lsu_ready, rsv_ready, busy_rs1, busy_rs2,
      input  WE3, AD3, WD3, busy_vec, err_unrsv
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  lsu_valid, lsu_rd, lsu_data,
      input  rsv_valid, rsv_rd, q_rs1, q_rs2,
      output alu_ready, lsu_ready, rsv_ready, busy_rs1, busy_rs2,
      output WE3, AD3, WD3, busy_vec, err_unrsv
   );
endinterface

// File: rtl/regfile_write_sched.sv
// rtl/regfile_write_sched.sv - round-robin write-port arbiter and pending-write scoreboard
module regfile_write_sched #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32
) (
   input logic                  clk,
   input logic                  rst,
   regfile_write_sched_if.slave bus
);
   localparam int NUM_REGS = 2**ADDRESS_WIDTH;

   typedef enum logic {
      GRANT_ALU = 1'b0,
      GRANT_LSU = 1'b1
   } grant_e;

   grant_e                   last_grant;
   grant_e                   last_grant_nxt;
   logic [NUM_REGS-1:0]      busy;
   logic [NUM_REGS-1:0]      busy_nxt;
   logic                     err;
   logic                     err_nxt;
   logic                     grant_alu;
   logic                     grant_lsu;
   logic                     grant;
   logic                     rsv_ok;
   logic [ADDRESS_WIDTH-1:0] wr_rd;
   logic [DATA_WIDTH-1:0]    wr_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy       <= '0;
         err        <= 1'b0;
         last_grant <= GRANT_LSU;
      end else begin
         busy       <= busy_nxt;
         err        <= err_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   always_comb begin
      grant_alu      = 1'b0;
      grant_lsu      = 1'b0;
      rsv_ok         = 1'b0;
      wr_rd          = '0;
      wr_data        = '0;
      busy_nxt       = busy;
      err_nxt        = err;
      last_grant_nxt = last_grant;

      // On contention the requester not named by last_grant wins.
      if (!rst) begin
         if (bus.alu_valid && (!bus.lsu_valid || last_grant == GRANT_LSU))
            grant_alu = 1'b1;
         else if (bus.lsu_valid)
            grant_lsu = 1'b1;
         rsv_ok = !busy[bus.rsv_rd];
      end
      grant = grant_alu | grant_lsu;

      if (grant_alu) begin
         wr_rd          = bus.alu_rd;
         wr_data        = bus.alu_data;
         last_grant_nxt = GRANT_ALU;
      end else if (grant_lsu) begin
         wr_rd          = bus.lsu_rd;
         wr_data        = bus.lsu_data;
         last_grant_nxt = GRANT_LSU;
      end

      if (grant) begin
         if (wr_rd != '0 && !busy[wr_rd])
            err_nxt = 1'b1;
         busy_nxt[wr_rd] = 1'b0;
      end
      if (bus.rsv_valid && rsv_ok)
         busy_nxt[bus.rsv_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Queries read registered state only, so a clearing register still reports busy.
   assign bus.alu_ready = grant_alu;
   assign bus.lsu_ready = grant_lsu;
   assign bus.rsv_ready = rsv_ok;
   assign bus.WE3       = grant && (wr_rd != '0);
   assign bus.AD3       = wr_rd;
   assign bus.WD3       = wr_data;
   assign bus.busy_vec  = busy;
   assign bus.busy_rs1  = busy[bus.q_rs1];
   assign bus.busy_rs2  = busy[bus.q_rs2];
   assign bus.err_unrsv = err;
endmodule

// File: tb/tb_regfile_write_sched.sv
// tb/tb_regfile_write_sched.sv - scoreboard bench for regfile_write_sched
module tb_regfile_write_sched;
   logic clk;
   logic rst;
   int   n_cmp  = 0;
   int   n_fail = 0;

   regfile_write_sched_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) bus ();

   regfile_write_sched #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        alu_r;
      logic        lsu_r;
      logic        rsv_r;
      logic        we;
      logic [4:0]  ad;
      logic [31:0] wd;
      logic [31:0] bv;
      logic        err;
      logic        b1;
      logic        b2;
   } exp_t;

   exp_t exp_q[$];

   // Reference state: set of pending registers, who won last, sticky error.
   bit pend[32];
   bit last_alu;
   bit err_m;
   bit acc_alu;
   bit acc_lsu;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pend_vec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = pend[i];
      return v;
   endfunction

   function automatic logic [4:0] pick_rd();
      int cand[$];
      for (int i = 1; i < 32; i++) if (pend[i]) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 7) != 0)
         return 5'(cand[$urandom_range(0, cand.size() - 1)]);
      return 5'($urandom_range(0, 31));
   endfunction

   // Computes expected outputs for the inputs now on the bus, then advances the model.
   task automatic drive();
      exp_t        e;
      int          w;
      logic [4:0]  wrd;
      logic [31:0] wdat;
      e.bv  = pend_vec();
      e.err = err_m;
      e.b1  = pend[bus.q_rs1];
      e.b2  = pend[bus.q_rs2];
      acc_alu = 0;
      acc_lsu = 0;
      if (rst) begin
         e.alu_r = 0; e.lsu_r = 0; e.rsv_r = 0; e.we = 0; e.ad = 0; e.wd = 0;
         exp_q.push_back(e);
         for (int i = 0; i < 32; i++) pend[i] = 0;
         err_m = 0;
         last_alu = 0;
         return;
      end
      if (bus.alu_valid && bus.lsu_valid) w = last_alu ? 2 : 1;
      else if (bus.alu_valid)             w = 1;
      else if (bus.lsu_valid)             w = 2;
      else                                w = 0;
      wrd  = (w == 1) ? bus.alu_rd   : (w == 2) ? bus.lsu_rd   : 5'd0;
      wdat = (w == 1) ? bus.alu_data : (w == 2) ? bus.lsu_data : 32'd0;
      e.alu_r = (w == 1);
      e.lsu_r = (w == 2);
      e.rsv_r = !pend[bus.rsv_rd];
      e.we    = (w != 0) && (wrd != 0);
      e.ad    = wrd;
      e.wd    = wdat;
      exp_q.push_back(e);
      acc_alu = (w == 1);
      acc_lsu = (w == 2);
      if (w != 0) begin
         if (wrd != 0 && !pend[wrd]) err_m = 1;
         pend[wrd] = 0;
         last_alu  = (w == 1);
      end
      if (bus.rsv_valid && e.rsv_r && bus.rsv_rd != 0) pend[bus.rsv_rd] = 1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      bus.alu_valid = v; bus.alu_rd = rd; bus.alu_data = d;
   endtask

   task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      bus.lsu_valid = v; bus.lsu_rd = rd; bus.lsu_data = d;
   endtask

   task automatic set_rsv(input logic v, input logic [4:0] rd);
      bus.rsv_valid = v; bus.rsv_rd = rd;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("ready", {bus.alu_ready, bus.lsu_ready, bus.rsv_ready}, {e.alu_r, e.lsu_r, e.rsv_r});
         chk("wport", {bus.WE3, bus.AD3, bus.WD3}, {e.we, e.ad, e.wd});
         chk("busy_vec", bus.busy_vec, e.bv);
         chk("err_unrsv", bus.err_unrsv, e.err);
         chk("busy_rs", {bus.busy_rs1, bus.busy_rs2}, {e.b1, e.b2});
      end
   end

   initial begin
      rst = 1;
      set_alu(0, 0, 0); set_lsu(0, 0, 0); set_rsv(0, 0);
      bus.q_rs1 = 0; bus.q_rs2 = 0;
      tick();
      drive(); #2;
      chk("rst_we3", bus.WE3, 0);
      chk("rst_ready", {bus.alu_ready, bus.lsu_ready, bus.rsv_ready}, 0);
      tick();
      rst = 0;

      // Reserve x5, then ALU writeback of x5.
      set_rsv(1, 5); drive(); #2; chk("t1_rsv_ready", bus.rsv_ready, 1); tick();
      set_rsv(0, 0); bus.q_rs1 = 5; set_alu(1, 5, 32'hDEADBEEF);
      drive(); #2;
      chk("t1_busy5", bus.busy_vec[5], 1);
      chk("t1_busy_rs1", bus.busy_rs1, 1);
      chk("t1_write", {bus.alu_ready, bus.WE3, bus.AD3, bus.WD3}, {1'b1, 1'b1, 5'd5, 32'hDEADBEEF});
      tick();
      set_alu(0, 0, 0); drive(); #2; chk("t1_cleared", bus.busy_vec[5], 0); tick();

      // Contention: ALU first, then LSU, then the repeat goes to LSU first.
      set_rsv(1, 7); drive(); tick();
      set_rsv(1, 9); drive(); tick();
      set_rsv(1, 8); set_lsu(1, 0, 32'h0); drive(); tick();
      set_rsv(0, 0); set_alu(1, 7, 32'h11); set_lsu(1, 9, 32'h22);
      drive(); #2; chk("t2_c1", {bus.alu_ready, bus.lsu_ready, bus.AD3}, {1'b1, 1'b0, 5'd7}); tick();
      set_alu(1, 8, 32'h33);
      drive(); #2; chk("t2_c2", {bus.alu_ready, bus.lsu_ready, bus.AD3}, {1'b0, 1'b1, 5'd9}); tick();
      set_lsu(0, 0, 0);
      drive(); #2; chk("t2_c3", bus.AD3, 8); tick();
      set_alu(0, 0, 0);
      set_rsv(1, 7); drive(); tick();
      set_rsv(1, 9); drive(); tick();
      set_rsv(0, 0); set_alu(1, 7, 32'h44); set_lsu(1, 9, 32'h55);
      drive(); #2; chk("t2_rep", {bus.alu_ready, bus.lsu_ready, bus.AD3}, {1'b0, 1'b1, 5'd9}); tick();
      set_lsu(0, 0, 0);
      drive(); #2; chk("t2_rep2", bus.AD3, 7); tick();
      set_alu(0, 0, 0);

      // WAW stall on x3 until its writeback has been accepted.
      set_rsv(1, 3); drive(); tick();
      drive(); #2; chk("t3_stall", bus.rsv_ready, 0); tick();
      set_lsu(1, 3, 32'hAB);
      drive(); #2; chk("t3_nobypass", {bus.rsv_ready, bus.lsu_ready}, {1'b0, 1'b1}); tick();
      set_lsu(0, 0, 0);
      drive(); #2; chk("t3_release", bus.rsv_ready, 1); tick();
      set_rsv(0, 0); set_lsu(1, 3, 32'h0); drive(); tick();
      set_lsu(0, 0, 0);

      // Write to x0 is accepted but not performed.
      set_alu(1, 0, 32'hFFFFFFFF);
      drive(); #2; chk("t4_x0", {bus.alu_ready, bus.WE3}, {1'b1, 1'b0}); tick();
      set_alu(0, 0, 0);
      drive(); #2; chk("t4_state", {bus.busy_vec, bus.err_unrsv}, 33'd0); tick();

      // Unreserved write sets the sticky error.
      set_alu(1, 12, 32'h1234);
      drive(); #2; chk("t5_write", {bus.WE3, bus.AD3}, {1'b1, 5'd12}); tick();
      set_alu(0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(); #2; chk("t5_sticky", bus.err_unrsv, 1); tick();
      end

      // Reset while both requesters are valid and x4 is busy.
      set_rsv(1, 4); drive(); tick();
      set_rsv(0, 0); set_alu(1, 1, 32'hA1); set_lsu(1, 2, 32'hB2); rst = 1;
      drive(); #2;
      chk("t6_rst_out", {bus.alu_ready, bus.lsu_ready, bus.rsv_ready, bus.WE3, bus.AD3, bus.WD3}, 0);
      tick();
      rst = 0;
      drive(); #2;
      chk("t6_after", {bus.busy_vec, bus.err_unrsv}, 33'd0);
      chk("t6_alu_first", {bus.alu_ready, bus.AD3}, {1'b1, 5'd1});
      tick();
      set_alu(0, 0, 0); drive(); tick();
      set_lsu(0, 0, 0);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 149) == 0);
         if (!bus.alu_valid && $urandom_range(0, 1) == 1) set_alu(1, pick_rd(), $urandom);
         if (!bus.lsu_valid && $urandom_range(0, 2) == 0) set_lsu(1, pick_rd(), $urandom);
         set_rsv($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)));
         bus.q_rs1 = 5'($urandom_range(0, 31));
         bus.q_rs2 = 5'($urandom_range(0, 31));
         drive();
         tick();
         if (acc_alu) bus.alu_valid = 0;
         if (acc_lsu) bus.lsu_valid = 0;
      end
      rst = 0;
      set_alu(0, 0, 0); set_lsu(0, 0, 0); set_rsv(0, 0);
      tick();
      chk("sb_drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_write_sched.md
Name: regfile_write_sched

Overview:
- Write-port scheduler and scoreboard for the 32x32 register file.
- Shares the register file's single write port (WE3/AD3/WD3) between two writeback requesters:
  - ALU writeback path
  - variable-latency load/store unit
- Tracks pending (reserved) destination registers so the issue stage can stall on RAW and WAW hazards.
- Sits between execute/memory writeback and the register file; the issue stage queries it.

Parameters:
ADDRESS_WIDTH, 5, register address width; 2**ADDRESS_WIDTH registers
DATA_WIDTH, 32, register data width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU request accepted this cycle
alu_rd  input  ADDRESS_WIDTH  ALU destination register
alu_data  input  DATA_WIDTH  ALU writeback data
lsu_valid  input  1  load unit writeback request
lsu_ready  output  1  load request accepted this cycle
lsu_rd  input  ADDRESS_WIDTH  load destination register
lsu_data  input  DATA_WIDTH  load writeback data
rsv_valid  input  1  issue stage reserves a destination register
rsv_rd  input  ADDRESS_WIDTH  register to reserve
rsv_ready  output  1  reservation accepted this cycle
q_rs1  input  ADDRESS_WIDTH  source register 1 query
q_rs2  input  ADDRESS_WIDTH  source register 2 query
busy_rs1  output  1  q_rs1 has a pending write
busy_rs2  output  1  q_rs2 has a pending write
WE3  output  1  register file write enable
AD3  output  ADDRESS_WIDTH  register file write address
WD3  output  DATA_WIDTH  register file write data
busy_vec  output  2**ADDRESS_WIDTH  scoreboard contents, bit 0 always 0
err_unrsv  output  1  sticky: write accepted to an unreserved nonzero register

Behaviour:
- Reset:
  - rst sampled on the rising clk edge only.
  - Clears busy_vec to 0 and err_unrsv to 0.
  - Sets last_grant to LSU, so the ALU wins the first contest.
  - While rst is high: alu_ready, lsu_ready, rsv_ready and WE3 are forced to 0, and AD3/WD3 are 0.
  - Reset mid-transfer drops any in-flight request. The requester re-presents it after reset.
- Handshake:
  - A transfer occurs in a cycle where valid && ready.
  - A requester holds valid, rd and data stable until ready.
  - ready is combinational in the same cycle (0-cycle acceptance).
  - The register file captures the data on the same clock edge.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: round-robin; the requester not named by last_grant wins.
  - last_grant updates on every accepted transfer.
  - The loser sees ready=0 and is granted next cycle if it is still valid.
  - No requester waits more than 1 cycle.
- Write port:
  - WE3 = grant && rd != 0.
  - AD3/WD3 = granted rd/data; both 0 when there is no grant.
  - A write to x0 is accepted (ready=1) but not written.
- Scoreboard:
  - busy[0] is hardwired to 0.
  - rsv_ready = !busy[rsv_rd] (WAW stall). rsv_ready is 1 for rsv_rd = 0.
  - No same-cycle bypass of a completing write: a register being cleared this cycle still reads busy.
  - Accepted reservation of rd != 0 sets busy[rd] at the next edge.
  - Accepted write clears busy[rd] at the next edge.
  - Reserve of rd A and write clear of rd B in the same cycle: both take effect.
  - Same rd in both cannot occur, because rsv_ready = 0 while busy.
- busy_rs1/busy_rs2 = busy[q_rs1]/busy[q_rs2] from the registered state (conservative during the clearing cycle).
- err_unrsv:
  - Set at the edge following an accepted write with rd != 0 and busy[rd] = 0.
  - Held until reset.
  - The write is still performed.

Test Plan:
- Reset, then reserve x5 → rsv_ready=1; next cycle busy_vec[5]=1, busy_rs1=1 for q_rs1=5. ALU writes x5=0xDEADBEEF → alu_ready=1, WE3=1, AD3=5, WD3=0xDEADBEEF in that cycle; busy_vec[5]=0 the cycle after.
- Reserve x7 and x9; assert alu_valid (x7, 0x11) and lsu_valid (x9, 0x22) together for 2 cycles:
  - Cycle 1: ALU granted (AD3=7).
  - Cycle 2: LSU granted (AD3=9).
  - Repeat the contest: LSU granted first.
- Reserve x3, then re-reserve x3 while it is busy → rsv_ready=0 until LSU writeback of x3 is accepted; rsv_ready=1 the cycle after.
- ALU write to x0 with data 0xFFFFFFFF → alu_ready=1, WE3=0, busy_vec=0, err_unrsv stays 0.
- ALU write to unreserved x12 → WE3=1, AD3=12; err_unrsv=1 from next cycle, held until rst.
- Assert rst for 1 cycle while both requesters are valid and x4 is busy → ready/WE3=0 during reset, busy_vec=0 after; the next contest goes to ALU.
